// File: rtl/powlib_sfifo_pkg.sv
// powlib_sfifo_pkg: shared helpers for the synchronous FIFO.
// powlib_clogb2(v) returns ceil(log2(v)) for sizing pointers.
package powlib_sfifo_pkg;

  function automatic int powlib_clogb2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_sfifo_dpram.sv
// powlib_sfifo_dpram: D x W storage, sync write, async read.
// Ports: clk, wridx/wrdata/wrvld (write), rdidx/rddata (read).
module powlib_sfifo_dpram #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = 3
) (
  input  logic            clk,
  input  logic [WIDX-1:0] wridx,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  input  logic [WIDX-1:0] rdidx,
  output logic [W-1:0]    rddata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (wrvld) mem[wridx] <= wrdata;
  end

  assign rddata = mem[rdidx];

endmodule

// File: rtl/powlib_sfifo.sv
// powlib_sfifo: synchronous FIFO, valid/ready on both sides.
// Ports: clk, rst (async low), clr, wr*/rd* handshakes, cnt, afull.
module powlib_sfifo
  import powlib_sfifo_pkg::*;
#(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int AFT  = D - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  output logic [WIDX:0] cnt,
  output logic          afull
);

  localparam logic [WIDX:0]   FULL = D[WIDX:0];
  localparam logic [WIDX:0]   THR  = AFT[WIDX:0];
  localparam logic [WIDX:0]   CONE = 1;
  localparam logic [WIDX-1:0] PONE = 1;

  logic [WIDX-1:0] wrptr;
  logic [WIDX-1:0] rdptr;
  logic [WIDX:0]   cnt_nxt;
  logic            wr_acc;
  logic            rd_acc;

  // Ready/valid come only from registered occupancy.
  assign wrrdy  = (cnt != FULL);
  assign rdvld  = (cnt != '0);
  assign wr_acc = wrvld && wrrdy;
  assign rd_acc = rdvld && rdrdy;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (wr_acc && !rd_acc)
      cnt_nxt = cnt + CONE;
    else if (!wr_acc && rd_acc)
      cnt_nxt = cnt - CONE;
  end

  // D is a power of two, so pointer wrap is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr <= '0;
      rdptr <= '0;
      cnt   <= '0;
      afull <= (AFT == 0);
    end else begin
      cnt   <= cnt_nxt;
      afull <= (cnt_nxt >= THR);
      if (clr) begin
        wrptr <= '0;
        rdptr <= '0;
      end else begin
        if (wr_acc) wrptr <= wrptr + PONE;
        if (rd_acc) rdptr <= rdptr + PONE;
      end
    end
  end

  // Flush suppresses the write so stale data never lands.
  powlib_sfifo_dpram #(
    .W    (W),
    .D    (D),
    .WIDX (WIDX)
  ) u_mem (
    .clk    (clk),
    .wridx  (wrptr),
    .wrdata (wrdata),
    .wrvld  (wr_acc && !clr),
    .rdidx  (rdptr),
    .rddata (rddata)
  );

endmodule

// File: tb/tb_powlib_sfifo.sv
// tb_powlib_sfifo: directed + random bench for powlib_sfifo.
// Config W=8, D=4, AFT=3.
module tb_powlib_sfifo;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] wrdata;
  logic       wrvld;
  logic       wrrdy;
  logic [7:0] rddata;
  logic       rdvld;
  logic       rdrdy;
  logic [2:0] cnt;
  logic       afull;

  int n_checks;
  int n_errors;

  logic [7:0] q[$];

  powlib_sfifo #(
    .W   (8),
    .D   (4),
    .AFT (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .cnt    (cnt),
    .afull  (afull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wrdata = d;
    wrvld  = 1'b1;
    tick();
    wrvld  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b0;
    clr    = 1'b0;
    wrdata = 8'hFF;
    wrvld  = 1'b1;
    rdrdy  = 1'b0;

    // reset with write pending
    tick();
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_wrrdy", 32'(wrrdy), 1);
    chk("rst_rdvld", 32'(rdvld), 0);
    chk("rst_afull", 32'(afull), 0);
    wrvld = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_cnt", 32'(cnt), 0);
    push(8'hA5);
    chk("a5_rdvld", 32'(rdvld), 1);
    chk("a5_data", 32'(rddata), 32'hA5);
    chk("a5_cnt", 32'(cnt), 1);
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;
    chk("a5_pop_cnt", 32'(cnt), 0);
    chk("a5_pop_vld", 32'(rdvld), 0);

    // fill to full, overflow attempt
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      chk("fill_cnt", 32'(cnt), 32'(i));
      chk("fill_afull", 32'(afull), (i >= 3) ? 1 : 0);
      chk("fill_wrrdy", 32'(wrrdy), (i < 4) ? 1 : 0);
    end
    push(8'h05);
    chk("ovf_cnt", 32'(cnt), 4);
    rdrdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(rddata), 32'(i));
      tick();
    end
    rdrdy = 1'b0;
    chk("drain_vld", 32'(rdvld), 0);
    chk("drain_cnt", 32'(cnt), 0);

    // simultaneous push/pop at cnt=2, across wrap
    push(8'h10);
    push(8'h11);
    wrvld = 1'b1;
    rdrdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wrdata = 8'(8'h12 + k);
      chk("sim_data", 32'(rddata), 32'(8'h10 + k));
      tick();
      chk("sim_cnt", 32'(cnt), 2);
    end
    wrvld = 1'b0;
    chk("sim_tail0", 32'(rddata), 32'h16);
    tick();
    chk("sim_tail1", 32'(rddata), 32'h17);
    tick();
    rdrdy = 1'b0;
    chk("sim_empty", 32'(rdvld), 0);

    // full plus pop
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    chk("fp_cnt4", 32'(cnt), 4);
    wrdata = 8'h24;
    wrvld  = 1'b1;
    rdrdy  = 1'b1;
    chk("fp_head", 32'(rddata), 32'h20);
    tick();
    wrvld = 1'b0;
    chk("fp_cnt3", 32'(cnt), 3);
    chk("fp_wrrdy", 32'(wrrdy), 1);
    for (int i = 1; i < 4; i++) begin
      chk("fp_data", 32'(rddata), 32'(8'h20 + i));
      tick();
    end
    rdrdy = 1'b0;
    chk("fp_empty", 32'(rdvld), 0);

    // flush with write pending
    push(8'h30);
    push(8'h31);
    push(8'h32);
    chk("cl_afull", 32'(afull), 1);
    clr    = 1'b1;
    wrvld  = 1'b1;
    wrdata = 8'h33;
    tick();
    clr   = 1'b0;
    wrvld = 1'b0;
    chk("cl_cnt", 32'(cnt), 0);
    chk("cl_vld", 32'(rdvld), 0);
    chk("cl_afull0", 32'(afull), 0);
    push(8'h5A);
    chk("cl_data", 32'(rddata), 32'h5A);
    chk("cl_cnt1", 32'(cnt), 1);
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;

    // reset mid-transfer
    push(8'h40);
    push(8'h41);
    rst = 1'b0;
    #1;
    chk("mr_cnt", 32'(cnt), 0);
    chk("mr_vld", 32'(rdvld), 0);
    tick();
    rst = 1'b1;
    tick();
    push(8'h42);
    chk("mr_data", 32'(rddata), 32'h42);
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;
    chk("mr_empty", 32'(cnt), 0);

    // random traffic against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic wa;
      logic ra;
      wrvld  = 1'($urandom_range(0, 1));
      rdrdy  = 1'($urandom_range(0, 1));
      wrdata = 8'($urandom);
      chk("rnd_cnt", 32'(cnt), 32'(q.size()));
      chk("rnd_afull", 32'(afull), (q.size() >= 3) ? 1 : 0);
      chk("rnd_vld", 32'(rdvld), (q.size() != 0) ? 1 : 0);
      if (q.size() != 0)
        chk("rnd_data", 32'(rddata), 32'(q[0]));
      wa = wrvld && (q.size() < 4);
      ra = rdrdy && (q.size() > 0);
      tick();
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(wrdata);
    end
    wrvld = 1'b0;
    rdrdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
